f1_light_seq: RTL and testbench

//  Parametrised F1 start-light sequencer with reaction timer. Lights fill one per

---
 rtl/f1_light_seq.sv | 141 ++++++++++++++
 tb/tb_f1_light_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/f1_light_seq.sv
// F1 start-light sequencer: lights fill one per en tick, hold for MIN_HOLD+LFSR ticks,
// go out together, then the clk cycles to react are counted. Optional macro: JUMP_START_DET_EN.
module f1_light_seq #(
    parameter int unsigned              N_LIGHTS  = 8,
    parameter int unsigned              LFSR_W    = 7,
    parameter logic [LFSR_W-1:0]        LFSR_TAPS = 7'b1100000,
    parameter int unsigned              MIN_HOLD  = 1,
    parameter int unsigned              RT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                trigger,
    input  logic                react,
    output logic [N_LIGHTS-1:0] data_out,
    output logic                busy,
    output logic                rt_valid,
    output logic [RT_W-1:0]     rt_count
`ifdef JUMP_START_DET_EN
    ,
    output logic                jump_start
`endif
);

    // Hold counter must fit MIN_HOLD plus the largest LFSR value.
    localparam int unsigned HC_W = $clog2(MIN_HOLD + (1 << LFSR_W) + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_HOLD,
        S_TIMING
    } state_t;

    state_t              r_state, w_state;
    logic [N_LIGHTS-1:0] r_data, w_data;
    logic [LFSR_W-1:0]   r_lfsr, w_lfsr;
    logic [HC_W-1:0]     r_hold, w_hold;
    logic [RT_W-1:0]     r_timer, w_timer;
    logic [RT_W-1:0]     r_rt_count, w_rt_count;
    logic                r_rt_valid, w_rt_valid;
    logic                w_abort;

`ifdef JUMP_START_DET_EN
    logic                r_jump, w_jump;
    assign w_abort    = react;
    assign jump_start = r_jump;
`else
    assign w_abort    = 1'b0;
`endif

    // Galois LFSR, free-running on every clk regardless of state or en.
    assign w_lfsr = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);

    always_comb begin
        w_state    = r_state;
        w_data     = r_data;
        w_hold     = r_hold;
        w_timer    = r_timer;
        w_rt_count = r_rt_count;
        w_rt_valid = 1'b0;
`ifdef JUMP_START_DET_EN
        w_jump     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_data = '0;
                if (trigger) begin
                    w_state = S_FILL;
                    w_data  = {{(N_LIGHTS-1){1'b0}}, 1'b1};
                end
            end
            S_FILL, S_HOLD: begin
                if (w_abort) begin
                    w_state = S_IDLE;
                    w_data  = '0;
`ifdef JUMP_START_DET_EN
                    w_jump  = 1'b1;
`endif
                end else if (en && r_state == S_FILL) begin
                    w_data = {r_data[N_LIGHTS-2:0], 1'b1};
                    if (&r_data[N_LIGHTS-2:0]) begin
                        w_state = S_HOLD;
                        w_hold  = HC_W'(MIN_HOLD) + HC_W'(r_lfsr);
                    end
                end else if (en) begin
                    w_hold = r_hold - HC_W'(1);
                    if (r_hold == HC_W'(1)) begin
                        w_state = S_TIMING;
                        w_data  = '0;
                        w_timer = '0;
                    end
                end
            end
            S_TIMING: begin
                if (r_timer != '1) w_timer = r_timer + RT_W'(1);
                if (react) begin
                    w_rt_count = r_timer;
                    w_rt_valid = 1'b1;
                    w_state    = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_data  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_data     <= '0;
            r_lfsr     <= LFSR_W'(1);
            r_hold     <= '0;
            r_timer    <= '0;
            r_rt_count <= '0;
            r_rt_valid <= 1'b0;
`ifdef JUMP_START_DET_EN
            r_jump     <= 1'b0;
`endif
        end else begin
            r_state    <= w_state;
            r_data     <= w_data;
            r_lfsr     <= w_lfsr;
            r_hold     <= w_hold;
            r_timer    <= w_timer;
            r_rt_count <= w_rt_count;
            r_rt_valid <= w_rt_valid;
`ifdef JUMP_START_DET_EN
            r_jump     <= w_jump;
`endif
        end
    end

    assign data_out = r_data;
    assign busy     = (r_state != S_IDLE);
    assign rt_valid = r_rt_valid;
    assign rt_count = r_rt_count;

endmodule

// File: tb/tb_f1_light_seq.sv
// Bench for f1_light_seq: light-count/hold-budget reference model checked every cycle,
// directed scenarios with literal expectations, then randomized runs.
module tb_f1_light_seq;

    localparam int N       = 8;
    localparam int MINH    = 1;
    localparam int RT_MAX  = 65535;
    localparam int RT4_MAX = 15;
`ifdef JUMP_START_DET_EN
    localparam bit JS = 1'b1;
`else
    localparam bit JS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, en, trigger, react;
    logic [7:0]  data_out, data_out4;
    logic        busy, busy4, rt_valid, rt_valid4;
    logic [15:0] rt_count;
    logic [3:0]  rt_count4;
`ifdef JUMP_START_DET_EN
    logic        jump_start, jump_start4;
`endif

    always #5 clk = ~clk;

    f1_light_seq #(.N_LIGHTS(8), .LFSR_W(7), .LFSR_TAPS(7'b1100000), .MIN_HOLD(1), .RT_W(16)) u_dut (
        .clk(clk), .rst(rst), .en(en), .trigger(trigger), .react(react),
        .data_out(data_out), .busy(busy), .rt_valid(rt_valid), .rt_count(rt_count)
`ifdef JUMP_START_DET_EN
        , .jump_start(jump_start)
`endif
    );

    f1_light_seq #(.N_LIGHTS(8), .LFSR_W(7), .LFSR_TAPS(7'b1100000), .MIN_HOLD(1), .RT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .trigger(trigger), .react(react),
        .data_out(data_out4), .busy(busy4), .rt_valid(rt_valid4), .rt_count(rt_count4)
`ifdef JUMP_START_DET_EN
        , .jump_start(jump_start4)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lfsr_next(input int v);
        return (v % 2 == 1) ? ((v / 2) ^ 'h60) : (v / 2);
    endfunction

    // Model: number of lit lamps, remaining hold ticks, cycles since lights-out.
    int m_lit, m_hold_left, m_hold_exp, m_cnt, m_lfsr, m_lfsr_now, m_rt, m_rt4;
    bit m_busy, m_timing, m_valid, m_jump;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lit = 0; m_hold_left = 0; m_hold_exp = 0; m_cnt = 0; m_lfsr = 1;
            m_rt = 0; m_rt4 = 0; m_busy = 0; m_timing = 0; m_valid = 0; m_jump = 0;
        end else begin
            m_lfsr_now = m_lfsr;
            m_lfsr     = lfsr_next(m_lfsr);
            m_valid    = 0;
            m_jump     = 0;
            if (!m_busy) begin
                if (trigger) begin m_busy = 1; m_lit = 1; end
            end else if (m_timing) begin
                if (react) begin
                    m_rt  = (m_cnt > RT_MAX)  ? RT_MAX  : m_cnt;
                    m_rt4 = (m_cnt > RT4_MAX) ? RT4_MAX : m_cnt;
                    m_valid = 1; m_busy = 0; m_timing = 0;
                end else m_cnt++;
            end else if (JS && react) begin
                m_busy = 0; m_lit = 0; m_jump = 1;
            end else if (en) begin
                if (m_lit < N) begin
                    m_lit++;
                    if (m_lit == N) begin
                        m_hold_left = MINH + m_lfsr_now;
                        m_hold_exp  = m_hold_left;
                    end
                end else begin
                    m_hold_left--;
                    if (m_hold_left == 0) begin m_lit = 0; m_timing = 1; m_cnt = 0; end
                end
            end
        end
    end

    logic [7:0] prev_data = '0;
    logic       en_s;
    int         hold_ticks = 0;

    always @(posedge clk) begin
        en_s = en;
        #1;
        if (!rst) begin
            chk("data_out", data_out, (1 << m_lit) - 1);
            chk("busy", busy, m_busy);
            chk("rt_valid", rt_valid, m_valid);
            chk("rt_count", rt_count, m_rt);
            chk("rt_count4", rt_count4, m_rt4);
`ifdef JUMP_START_DET_EN
            chk("jump_start", jump_start, m_jump);
`endif
            if (prev_data == 8'hFF && en_s) hold_ticks++;
            if (prev_data == 8'hFF && data_out == 8'h00 && m_timing) begin
                chk("hold_len", hold_ticks, m_hold_exp);
                chk("hold_range", (hold_ticks >= 1 && hold_ticks <= 128), 1);
            end
            if (data_out == 8'hFF && prev_data != 8'hFF) hold_ticks = 0;
            prev_data = data_out;
        end
    end

    task automatic step(input logic t, input logic e, input logic r);
        trigger = t; en = e; react = r;
        @(negedge clk);
    endtask

    task automatic run_to_timing();
        for (int k = 0; k < 400 && !m_timing; k++) step(1'b0, 1'b1, 1'b0);
        chk("timing_reached", m_timing, 1);
        chk("lights_out", data_out, 8'h00);
    endtask

    logic [7:0] fill_tab [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

    initial begin
        rst = 1'b1; trigger = 1'b0; en = 1'b0; react = 1'b0;
        // Pin the LFSR model against hand-stepped values and its period.
        chk("lfsr_pin1", lfsr_next(1), 'h60);
        chk("lfsr_pin2", lfsr_next('h60), 'h30);
        chk("lfsr_pin3", lfsr_next(3), 'h61);
        begin
            int v = 1, p = 0;
            do begin v = lfsr_next(v); p++; end while (v != 1 && p < 200);
            chk("lfsr_period", p, 127);
        end
        repeat (2) @(negedge clk);
        chk("rst_data", data_out, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", rt_valid, 1'b0);
        chk("rst_rt", rt_count, 16'd0);
        rst = 1'b0;

        // Fill sequence, one light per tick.
        step(1'b1, 1'b0, 1'b0);
        chk("fill0", data_out, fill_tab[0]);
        for (int i = 1; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("fill", data_out, fill_tab[i]);
            chk("fill_busy", busy, 1'b1);
        end

        // Asynchronous reset mid-hold, then a clean restart.
        #2 rst = 1'b1;
        #1;
        chk("arst_data", data_out, 8'h00);
        chk("arst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        chk("restart", data_out, 8'h01);

        // Full run with react 37 clks after lights-out.
        run_to_timing();
        repeat (37) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("rt37_valid", rt_valid, 1'b1);
        chk("rt37", rt_count, 16'd37);
        chk("rt37_sat4", rt_count4, 4'd15);
        chk("rt37_busy", busy, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("rt_valid_pulse", rt_valid, 1'b0);

        // Saturation of the narrow counter after 40 clks.
        step(1'b1, 1'b0, 1'b0);
        run_to_timing();
        repeat (40) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("rt40", rt_count, 16'd40);
        chk("rt40_sat4", rt_count4, 4'd15);

        // React during fill.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("fill07", data_out, 8'h07);
        step(1'b0, 1'b0, 1'b1);
`ifdef JUMP_START_DET_EN
        chk("js_pulse", jump_start, 1'b1);
        chk("js_data", data_out, 8'h00);
        chk("js_busy", busy, 1'b0);
        chk("js_rt_kept", rt_count, 16'd40);
`else
        chk("nojs_data", data_out, 8'h07);
        chk("nojs_busy", busy, 1'b1);
        run_to_timing();
        step(1'b0, 1'b0, 1'b1);
        chk("nojs_valid", rt_valid, 1'b1);
        chk("nojs_rt0", rt_count, 16'd0);
`endif
        step(1'b0, 1'b0, 1'b0);

        // Randomized operation against the model.
        for (int c = 0; c < 20000; c++) begin
            logic t, e, r;
            t = ($urandom_range(0, 3) == 0);
            e = $urandom_range(0, 1) != 0;
            r = m_timing ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 31) == 0);
            step(t, e, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
